// File: rtl/rv64g_pkg.sv
// rtl/rv64g_pkg.sv - RV64G opcode constants, decode class indices and stage payload type
package rv64g_pkg;

  localparam int NUM_CLASS = 18;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
  localparam logic [6:0] OPC_AMO       = 7'b0101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_FP_FMA    = 7'b1000011;
  localparam logic [6:0] OPC_OP_FP     = 7'b1010011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [6:0] MASK_FULL     = 7'b1111111;
  // FMADD/FMSUB/FNMSUB/FNMADD differ only in bits [3:2]
  localparam logic [6:0] MASK_FP_FMA   = 7'b1110011;

  typedef enum logic [4:0] {
    CLS_LOAD      = 5'd0,
    CLS_LOAD_FP   = 5'd1,
    CLS_MISC_MEM  = 5'd2,
    CLS_OP_IMM    = 5'd3,
    CLS_AUIPC     = 5'd4,
    CLS_OP_IMM_32 = 5'd5,
    CLS_STORE     = 5'd6,
    CLS_STORE_FP  = 5'd7,
    CLS_AMO       = 5'd8,
    CLS_OP        = 5'd9,
    CLS_LUI       = 5'd10,
    CLS_OP_32     = 5'd11,
    CLS_FP_FMA    = 5'd12,
    CLS_OP_FP     = 5'd13,
    CLS_BRANCH    = 5'd14,
    CLS_JALR      = 5'd15,
    CLS_JAL       = 5'd16,
    CLS_SYSTEM    = 5'd17
  } class_idx_e;

  typedef struct packed {
    logic [31:0]          instr;
    logic [NUM_CLASS-1:0] cls;
    logic                 illegal;
  } dec_payload_t;

  function automatic logic [6:0] class_value(input logic [4:0] idx);
    case (idx)
      CLS_LOAD:      return OPC_LOAD;
      CLS_LOAD_FP:   return OPC_LOAD_FP;
      CLS_MISC_MEM:  return OPC_MISC_MEM;
      CLS_OP_IMM:    return OPC_OP_IMM;
      CLS_AUIPC:     return OPC_AUIPC;
      CLS_OP_IMM_32: return OPC_OP_IMM_32;
      CLS_STORE:     return OPC_STORE;
      CLS_STORE_FP:  return OPC_STORE_FP;
      CLS_AMO:       return OPC_AMO;
      CLS_OP:        return OPC_OP;
      CLS_LUI:       return OPC_LUI;
      CLS_OP_32:     return OPC_OP_32;
      CLS_FP_FMA:    return OPC_FP_FMA;
      CLS_OP_FP:     return OPC_OP_FP;
      CLS_BRANCH:    return OPC_BRANCH;
      CLS_JALR:      return OPC_JALR;
      CLS_JAL:       return OPC_JAL;
      CLS_SYSTEM:    return OPC_SYSTEM;
      default:       return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] class_mask(input logic [4:0] idx);
    return (idx == CLS_FP_FMA) ? MASK_FP_FMA : MASK_FULL;
  endfunction

endpackage

// File: rtl/constant_compare.sv
// rtl/constant_compare.sv - masked compare of an input against a constant, mapped to two output codes
module constant_compare #(
  parameter int                    IP_WIDTH    = 7,
  parameter int                    OP_WIDTH    = 1,
  parameter logic [OP_WIDTH-1:0]   MATCH_TRUE  = OP_WIDTH'(1),
  parameter logic [OP_WIDTH-1:0]   MATCH_FALSE = OP_WIDTH'(0)
) (
  input  logic [IP_WIDTH-1:0] a_i,
  input  logic [IP_WIDTH-1:0] mask_i,
  input  logic [IP_WIDTH-1:0] value_i,
  output logic [OP_WIDTH-1:0] match_o
);

  assign match_o = ((a_i & mask_i) == value_i) ? MATCH_TRUE : MATCH_FALSE;

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - opcode-class decode stage with main + skid register handshake
module instr_decode_stage
  import rv64g_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 flush_i,
  input  logic [31:0]          instr_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [31:0]          instr_o,
  output logic [XLEN-1:0]      pc_o,
  output logic [NUM_CLASS-1:0] class_o,
  output logic                 illegal_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  typedef struct packed {
    dec_payload_t    dec;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [NUM_CLASS-1:0] cls_match;
  entry_t               in_entry;
  entry_t               main_d, main_q, skid_d, skid_q;
  logic                 main_valid_d, main_valid_q;
  logic                 skid_valid_d, skid_valid_q;
  logic                 accept_in;

  for (genvar g = 0; g < NUM_CLASS; g++) begin : g_class
    constant_compare #(
      .IP_WIDTH   (7),
      .OP_WIDTH   (1),
      .MATCH_TRUE (1'b1),
      .MATCH_FALSE(1'b0)
    ) u_cmp (
      .a_i    (instr_i[6:0]),
      .mask_i (class_mask(5'(g))),
      .value_i(class_value(5'(g))),
      .match_o(cls_match[g])
    );
  end

  always_comb begin
    in_entry             = '0;
    in_entry.dec.instr   = instr_i;
    in_entry.dec.cls     = cls_match;
    in_entry.dec.illegal = ~|cls_match;
    in_entry.pc          = pc_i;
  end

  assign accept_in = valid_i & ready_o;

  // A full skid implies a full main, so ready_o=0 and no new accept can collide with the refill.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || ready_i) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept_in;
        if (accept_in) main_d = in_entry;
      end
    end else if (accept_in) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign ready_o   = ~skid_valid_q;
  assign valid_o   = main_valid_q;
  assign instr_o   = main_q.dec.instr;
  assign pc_o      = main_q.pc;
  assign class_o   = main_q.dec.cls;
  assign illegal_o = main_q.dec.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed vector and sequence bench for instr_decode_stage
module tb_instr_decode_stage;

  localparam int XLEN = 64;

  logic              clk = 1'b0;
  logic              arst_ni;
  logic              flush_i;
  logic [31:0]       instr_i;
  logic [XLEN-1:0]   pc_i;
  logic              valid_i;
  logic              ready_o;
  logic [31:0]       instr_o;
  logic [XLEN-1:0]   pc_o;
  logic [17:0]       class_o;
  logic              illegal_o;
  logic              valid_o;
  logic              ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  instr_decode_stage #(.XLEN(XLEN)) dut (
    .clk_i    (clk),
    .arst_ni  (arst_ni),
    .flush_i  (flush_i),
    .instr_i  (instr_i),
    .pc_i     (pc_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .instr_o  (instr_o),
    .pc_o     (pc_o),
    .class_o  (class_o),
    .illegal_o(illegal_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [17:0] cls;
    logic        ill;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " valid_o"},   64'(valid_o),   64'd0);
    chk({tag, " ready_o"},   64'(ready_o),   64'd1);
    chk({tag, " instr_o"},   64'(instr_o),   64'd0);
    chk({tag, " pc_o"},      pc_o,           64'd0);
    chk({tag, " class_o"},   64'(class_o),   64'd0);
    chk({tag, " illegal_o"}, 64'(illegal_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] got[$];
    logic [31:0] exp_instr;
    int sent, rcvd, falls, extra;
    logic prev_ready;

    vecs[0]  = '{32'h00000013, 64'h80000000, 18'h00008, 1'b0};
    vecs[1]  = '{32'h00000000, 64'h80000004, 18'h00000, 1'b1};
    vecs[2]  = '{32'hFFFFFFFF, 64'h80000008, 18'h00000, 1'b1};
    vecs[3]  = '{32'h0000004F, 64'h8000000C, 18'h01000, 1'b0};
    vecs[4]  = '{32'h00000073, 64'h80000010, 18'h20000, 1'b0};
    vecs[5]  = '{32'h00003003, 64'h80000014, 18'h00001, 1'b0};
    vecs[6]  = '{32'h0000006F, 64'h80000018, 18'h10000, 1'b0};
    vecs[7]  = '{32'h12345037, 64'h8000001C, 18'h00400, 1'b0};
    vecs[8]  = '{32'h00000043, 64'h80000020, 18'h01000, 1'b0};
    vecs[9]  = '{32'h00000053, 64'h80000024, 18'h02000, 1'b0};
    vecs[10] = '{32'h0000002F, 64'h80000028, 18'h00100, 1'b0};
    vecs[11] = '{32'h0000007B, 64'h8000002C, 18'h00000, 1'b1};
    vecs[12] = '{32'h00000057, 64'h80000030, 18'h00000, 1'b1};
    vecs[13] = '{32'h00000012, 64'hFFFFFFFFFFFFFFF0, 18'h00000, 1'b1};

    arst_ni = 1'b0;
    flush_i = 1'b0;
    instr_i = '0;
    pc_i    = '0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    arst_ni = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      valid_i = 1'b1;
      ready_i = 1'b1;
      instr_i = vecs[i].instr;
      pc_i    = vecs[i].pc;
      step();
      chk($sformatf("vec%0d valid_o", i),   64'(valid_o),   64'd1);
      chk($sformatf("vec%0d class_o", i),   64'(class_o),   64'(vecs[i].cls));
      chk($sformatf("vec%0d illegal_o", i), 64'(illegal_o), 64'(vecs[i].ill));
      chk($sformatf("vec%0d pc_o", i),      pc_o,           vecs[i].pc);
      chk($sformatf("vec%0d instr_o", i),   64'(instr_o),   64'(vecs[i].instr));
    end
    valid_i = 1'b0;
    step();
    chk("drain valid_o", 64'(valid_o), 64'd0);

    sent = 0;
    rcvd = 0;
    falls = 0;
    prev_ready = ready_o;
    for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
      valid_i = (sent < 8);
      instr_i = 32'h00000013 | (32'(sent) << 7);
      pc_i    = 64'h1000 + 64'(sent) * 4;
      ready_i = !(cyc == 3 || cyc == 4);
      if (prev_ready && !ready_o) falls++;
      prev_ready = ready_o;
      if (valid_o && ready_i) begin
        got.push_back(instr_o);
        rcvd++;
      end
      if (valid_i && ready_o) sent++;
      step();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk("stream outputs", 64'(rcvd), 64'd8);
    chk("stream ready falls", 64'(falls), 64'd1);
    for (int k = 0; k < got.size(); k++) begin
      exp_instr = 32'h00000013 | (32'(k) << 7);
      chk($sformatf("stream order %0d", k), 64'(got[k]), 64'(exp_instr));
    end
    step();
    step();

    ready_i = 1'b0;
    valid_i = 1'b1;
    instr_i = 32'h00A00013;
    step();
    instr_i = 32'h00B00013;
    step();
    chk("full ready_o", 64'(ready_o), 64'd0);
    chk("full instr_o", 64'(instr_o), 64'h00A00013);
    instr_i = 32'h00C00013;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("flush valid_o", 64'(valid_o), 64'd0);
    chk("flush ready_o", 64'(ready_o), 64'd1);
    ready_i = 1'b1;
    valid_i = 1'b1;
    instr_i = 32'h00D00013;
    step();
    valid_i = 1'b0;
    chk("post-flush valid_o", 64'(valid_o), 64'd1);
    chk("post-flush instr_o", 64'(instr_o), 64'h00D00013);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (valid_o) extra++;
    end
    chk("flush no ghost outputs", 64'(extra), 64'd0);

    valid_i = 1'b1;
    ready_i = 1'b1;
    instr_i = 32'h00E00013;
    step();
    chk("pre-reset instr_o", 64'(instr_o), 64'h00E00013);
    instr_i = 32'h00F00013;
    #3;
    arst_ni = 1'b0;
    #1;
    chk_zero_outputs("async reset");
    @(negedge clk);
    chk_zero_outputs("held reset");
    instr_i = 32'h0000006F;
    pc_i    = 64'h2000;
    arst_ni = 1'b1;
    step();
    valid_i = 1'b0;
    chk("resume valid_o", 64'(valid_o), 64'd1);
    chk("resume instr_o", 64'(instr_o), 64'h0000006F);
    chk("resume class_o", 64'(class_o), 64'h10000);
    chk("resume pc_o", pc_o, 64'h2000);
    step();
    chk("resume drain valid_o", 64'(valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning program-counter width.
REQ-002 SHALL have parameter NUM_CLASS, default 18, meaning opcode-class vector width; fixed by the package, not overridable.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port arst_ni, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port flush_i, input, 1, synchronous pipeline flush.
REQ-006 SHALL have ports instr_i (input, 32, fetched instruction), pc_i (input, XLEN, its address), valid_i (input, 1), ready_o (output, 1).
REQ-007 SHALL have ports instr_o (output, 32), pc_o (output, XLEN), class_o (output, NUM_CLASS, one-hot opcode class), illegal_o (output, 1), valid_o (output, 1), ready_i (input, 1).

Function
REQ-008 SHALL transfer input when valid_i & ready_o and output when valid_o & ready_i at a clock edge; valid_i and its payload are held stable until accepted.
REQ-009 SHALL classify instr_i[6:0] combinationally on the input side and register class_o/illegal_o with the payload; latency is 1 cycle from input transfer to valid_o.
REQ-010 SHALL assign class bits: 0 LOAD 0000011, 1 LOAD_FP 0000111, 2 MISC_MEM 0001111, 3 OP_IMM 0010011, 4 AUIPC 0010111, 5 OP_IMM_32 0011011, 6 STORE 0100011, 7 STORE_FP 0100111, 8 AMO 0101111, 9 OP 0110011, 10 LUI 0110111, 11 OP_32 0111011, 12 FP_FMA (mask 1110011, value 1000011), 13 OP_FP 1010011, 14 BRANCH 1100011, 15 JALR 1100111, 16 JAL 1101111, 17 SYSTEM 1110011.
REQ-011 SHALL set illegal_o=1 and class_o=0 when no class matches, including any instr_i[1:0]!=2'b11.
REQ-012 SHALL contain a main register and one skid register, each holding {instr, pc, class, illegal, valid}.
REQ-013 SHALL drive ready_o = ~skid_valid as a registered term, with no combinational path from ready_i.
REQ-014 SHALL drive the outputs from the main register only; valid_o = main_valid.
REQ-015 On input transfer while the main register is empty or being drained this cycle, SHALL load the main register.
REQ-016 On input transfer while the main register is full and not drained, SHALL load the skid register.
REQ-017 On output transfer with the skid register full, SHALL move skid to main and clear skid_valid.
REQ-018 SHALL sustain one transfer per cycle when ready_i is held high; throughput SHALL never drop because of the skid.
REQ-019 SHALL hold the outputs stable while valid_o & ~ready_i.
REQ-020 On flush_i=1, SHALL clear main_valid and skid_valid at that edge, discarding any simultaneous input transfer; ready_o=1 the next cycle.
REQ-021 SHALL count the flush cycle's input handshake as accepted-and-dropped; the upstream stage does not resend it.

Reset
REQ-022 While arst_ni=0, SHALL force main_valid=0, skid_valid=0, valid_o=0, ready_o=1, instr_o=0, pc_o=0, class_o=0, illegal_o=0.
REQ-023 Reset assertion mid-transfer SHALL drop all held entries immediately; the first accept is possible at the first edge after deassertion.

Structure
REQ-024 SHALL place the opcode constants, the class-index enum, NUM_CLASS and the stage payload struct in the shared rv64g package.
REQ-025 SHALL implement each class match as one constant_compare instance (IP_WIDTH=7, OP_WIDTH=1, MATCH_TRUE=1, MATCH_FALSE=0); it is the only sub-module.

Verification
REQ-026 SHALL check that 0x00000013 at pc 0x80000000 with ready_i=1 gives, the next cycle, valid_o=1, class_o bit 3 only, illegal_o=0, pc_o=0x80000000.
REQ-027 SHALL check that 0x00000000 and 0xFFFFFFFF each give illegal_o=1 and class_o=0.
REQ-028 SHALL check that 0x0000004F (FNMADD) sets bit 12 and 0x00000073 sets bit 17.
REQ-029 SHALL check back-to-back valid_i for 8 cycles with ready_i low for cycles 3-4: ready_o falls exactly once, no loss, order preserved, 8 outputs.
REQ-030 SHALL check flush_i with both registers full and valid_i=1: next cycle valid_o=0, ready_o=1, and the dropped instruction never appears.
REQ-031 SHALL check arst_ni pulsed low mid-stream: outputs are zero asynchronously, and streaming resumes cleanly after release.
